// File: rtl/fsmc_mux_master_pkg.sv
// Shared definitions for the muxed FSMC bus master: phase encodings, bus widths
// and the address-map constant also used by the FPGA-side responder.
package fsmc_mux_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_AHOLD = 3'd2,
    S_DATA  = 3'd3,
    S_TURN  = 3'd4
  } fsmc_state_t;

  localparam int FSMC_ADDR_W = 19;
  localparam int FSMC_DATA_W = 16;
  localparam int CNT_W       = 4;

  localparam logic [FSMC_ADDR_W-1:0] BUF1_ADDR = 19'h50001;

  // Phase counters run N-1 .. 0, so a phase of N clocks loads N-1.
  function automatic logic [CNT_W-1:0] phase_load(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/fsmc_mux_master_phase_cnt.sv
// Loadable 4-bit phase down-counter; stops at zero and can be frozen by i_hold.
module fsmc_mux_master_phase_cnt
  import fsmc_mux_master_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_hold,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (!i_hold && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fsmc_mux_master.sv
// Single-transaction initiator for the 16-bit muxed FSMC bus with fixed phase timing.
// Optional FSMC_NWAIT_EN adds a synchronised NWAIT input that stretches the data phase.
module fsmc_mux_master
  import fsmc_mux_master_pkg::*;
#(
  parameter int unsigned ADDSET  = 2,
  parameter int unsigned ADDHLD  = 1,
  parameter int unsigned DATAST  = 3,
  parameter int unsigned BUSTURN = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_rnw,
  input  logic [FSMC_ADDR_W-1:0] req_addr,
  input  logic [FSMC_DATA_W-1:0] req_wdata,
  output logic                   rsp_valid,
  output logic [FSMC_DATA_W-1:0] rsp_rdata,
  output logic                   NE,
  output logic                   NADV,
  output logic                   NOE,
  output logic                   NWE,
  output logic [2:0]             A_HI,
  output logic [FSMC_DATA_W-1:0] ad_out,
  output logic                   ad_oe,
  input  logic [FSMC_DATA_W-1:0] ad_in
`ifdef FSMC_NWAIT_EN
  ,
  input  logic                   NWAIT
`endif
);

  fsmc_state_t            r_state, w_state_nxt;
  logic                   w_hs, w_zero, w_load, w_wait, w_hold;
  logic [CNT_W-1:0]       w_load_val;
  logic                   r_rnw;
  logic [FSMC_DATA_W-1:0] r_wdata;
  logic                   r_ne, r_nadv, r_noe, r_nwe, r_ad_oe, r_rsp_valid;
  logic [2:0]             r_a_hi;
  logic [FSMC_DATA_W-1:0] r_ad_out, r_rsp_rdata;

`ifdef FSMC_NWAIT_EN
  logic r_nwait_s1, r_nwait_s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_nwait_s1 <= 1'b1;
      r_nwait_s2 <= 1'b1;
    end else begin
      r_nwait_s1 <= NWAIT;
      r_nwait_s2 <= r_nwait_s1;
    end
  end

  assign w_wait = ~r_nwait_s2;
`else
  assign w_wait = 1'b0;
`endif

  assign req_ready = (r_state == S_IDLE) && rst_n;
  assign w_hs      = req_valid && req_ready;
  assign w_hold    = (r_state == S_DATA) && w_wait;

  fsmc_mux_master_phase_cnt u_phase_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_hold     (w_hold),
    .o_zero     (w_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    case (r_state)
      S_IDLE:  if (w_hs) begin
                 w_state_nxt = S_ADDR;  w_load = 1'b1; w_load_val = phase_load(ADDSET);
               end
      S_ADDR:  if (w_zero) begin
                 w_state_nxt = S_AHOLD; w_load = 1'b1; w_load_val = phase_load(ADDHLD);
               end
      S_AHOLD: if (w_zero) begin
                 w_state_nxt = S_DATA;  w_load = 1'b1; w_load_val = phase_load(DATAST);
               end
      S_DATA:  if (w_zero && !w_wait) begin
                 w_state_nxt = S_TURN;  w_load = 1'b1; w_load_val = phase_load(BUSTURN);
               end
      S_TURN:  if (w_zero) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pins are registered from the next state so each phase shows on the bus
  // in the same cycle the FSM enters it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rnw       <= 1'b0;
      r_wdata     <= '0;
      r_ne        <= 1'b1;
      r_nadv      <= 1'b1;
      r_noe       <= 1'b1;
      r_nwe       <= 1'b1;
      r_ad_oe     <= 1'b0;
      r_ad_out    <= '0;
      r_a_hi      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= 1'b0;
      if (w_hs) begin
        r_rnw    <= req_rnw;
        r_wdata  <= req_wdata;
        r_ad_out <= req_addr[15:0];
        r_a_hi   <= req_addr[18:16];
      end
      case (w_state_nxt)
        S_ADDR: begin
          r_ne <= 1'b0; r_nadv <= 1'b0; r_noe <= 1'b1; r_nwe <= 1'b1; r_ad_oe <= 1'b1;
        end
        S_AHOLD: begin
          r_ne <= 1'b0; r_nadv <= 1'b1;
        end
        S_DATA: begin
          r_ne <= 1'b0; r_nadv <= 1'b1;
          if (r_rnw) begin
            r_noe <= 1'b0; r_ad_oe <= 1'b0;
          end else begin
            r_nwe <= 1'b0; r_ad_oe <= 1'b1; r_ad_out <= r_wdata;
          end
        end
        default: begin
          r_ne <= 1'b1; r_nadv <= 1'b1; r_noe <= 1'b1; r_nwe <= 1'b1; r_ad_oe <= 1'b0;
        end
      endcase
      if ((r_state == S_DATA) && (w_state_nxt == S_TURN)) begin
        r_rsp_valid <= 1'b1;
        if (r_rnw) r_rsp_rdata <= ad_in;
      end
    end
  end

  assign NE        = r_ne;
  assign NADV      = r_nadv;
  assign NOE       = r_noe;
  assign NWE       = r_nwe;
  assign A_HI      = r_a_hi;
  assign ad_out    = r_ad_out;
  assign ad_oe     = r_ad_oe;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

endmodule
